// File: rtl/pulse_qualifier.sv
// Input conditioner: synchronises a raw asynchronous level, glitch-filters it and
// emits one single-cycle pulse per qualified rising edge, followed by a holdoff window.
module pulse_qualifier #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int HOLDOFF     = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             async_in,
    input  logic             enable,
    input  logic             clr_stats,
    output logic             pulse_out,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic             dropped
);

    localparam int FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOW = 2'd0,
        ST_ARMED    = 2'd1,
        ST_FIRE     = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic [SYNC_STAGES-1:0] sync_vld_r;
    logic                   s_d_r;
    logic                   s_s;
    logic                   sync_valid_s;
    logic                   rise_s;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [FW-1:0]          filt_cnt_r;
    logic [FW-1:0]          filt_next_s;
    logic [HW-1:0]          hold_cnt_r;
    logic [HW-1:0]          hold_next_s;

    logic                   pulse_r;
    logic [CNT_W-1:0]       pulse_cnt_r;
    logic                   dropped_r;
    logic                   fire_event_s;
    logic                   drop_event_s;

    assign s_s          = sync_r[SYNC_STAGES-1];
    assign sync_valid_s = sync_vld_r[SYNC_STAGES-1];
    assign rise_s       = s_s & ~s_d_r;

    // The valid chain marks when the synchroniser holds real samples again after
    // reset; without it a level stuck high through reset would look like a fresh low.
    // Synchroniser chain, its valid tracker and the one-cycle delayed sync output.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r     <= '0;
            sync_vld_r <= '0;
            s_d_r      <= 1'b0;
        end else begin
            sync_r     <= {sync_r[SYNC_STAGES-2:0], async_in};
            sync_vld_r <= {sync_vld_r[SYNC_STAGES-2:0], 1'b1};
            s_d_r      <= s_s;
        end
    end

    // Qualifier FSM state and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_WAIT_LOW;
            filt_cnt_r <= '0;
            hold_cnt_r <= '0;
        end else begin
            state_r    <= state_next_s;
            filt_cnt_r <= filt_next_s;
            hold_cnt_r <= hold_next_s;
        end
    end

    // Next-state and counter logic; enable low parks the FSM idle.
    always_comb begin
        state_next_s = state_r;
        filt_next_s  = filt_cnt_r;
        hold_next_s  = hold_cnt_r;
        if (!enable) begin
            state_next_s = ST_WAIT_LOW;
            filt_next_s  = '0;
            hold_next_s  = '0;
        end else begin
            case (state_r)
                ST_WAIT_LOW: begin
                    filt_next_s = '0;
                    if (sync_valid_s && !s_s) begin
                        state_next_s = ST_ARMED;
                    end else begin
                        state_next_s = ST_WAIT_LOW;
                    end
                end
                ST_ARMED: begin
                    if (s_s) begin
                        if (filt_cnt_r == FILT_LAST) begin
                            state_next_s = ST_FIRE;
                            filt_next_s  = '0;
                        end else begin
                            filt_next_s  = filt_cnt_r + FW'(1);
                        end
                    end else begin
                        filt_next_s = '0;
                    end
                end
                ST_FIRE: begin
                    state_next_s = ST_HOLD;
                    hold_next_s  = '0;
                end
                ST_HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_next_s = ST_WAIT_LOW;
                        hold_next_s  = '0;
                    end else begin
                        hold_next_s  = hold_cnt_r + HW'(1);
                    end
                end
                default: begin
                    state_next_s = ST_WAIT_LOW;
                    filt_next_s  = '0;
                    hold_next_s  = '0;
                end
            endcase
        end
    end

    // A pulse already on the output is counted even if enable drops in that cycle.
    assign fire_event_s = (state_r == ST_FIRE);
    assign drop_event_s = enable && (state_r == ST_HOLD) && rise_s;

    // Output pulse register, high exactly while the FSM sits in FIRE.
    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_r <= 1'b0;
        end else begin
            pulse_r <= (state_next_s == ST_FIRE);
        end
    end

    // Debug statistics: saturating pulse count and sticky drop flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_cnt_r <= '0;
            dropped_r   <= 1'b0;
        end else if (clr_stats) begin
            pulse_cnt_r <= '0;
            dropped_r   <= 1'b0;
        end else begin
            if (fire_event_s && (pulse_cnt_r != {CNT_W{1'b1}})) begin
                pulse_cnt_r <= pulse_cnt_r + CNT_W'(1);
            end
            if (drop_event_s) begin
                dropped_r <= 1'b1;
            end
        end
    end

    assign pulse_out = pulse_r;
    assign pulse_cnt = pulse_cnt_r;
    assign dropped   = dropped_r;

endmodule

// File: tb/tb_pulse_qualifier.sv
// Directed self-checking bench for pulse_qualifier; a second instance with a
// 2-bit counter shares the stimulus to exercise counter saturation.
module tb_pulse_qualifier;

    logic       clk = 1'b0;
    logic       reset;
    logic       async_in;
    logic       enable;
    logic       clr_stats;
    logic       pulse_out;
    logic [7:0] pulse_cnt;
    logic       dropped;
    logic       pulse_out2;
    logic [1:0] pulse_cnt2;
    logic       dropped2;

    int checks   = 0;
    int failures = 0;
    int seen     = 0;
    int long_cnt = 0;
    logic prev_p = 1'b0;

    always #5 clk = ~clk;

    pulse_qualifier #(.SYNC_STAGES(2), .FILT_CYCLES(4), .HOLDOFF(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .async_in(async_in), .enable(enable),
        .clr_stats(clr_stats), .pulse_out(pulse_out), .pulse_cnt(pulse_cnt),
        .dropped(dropped)
    );

    pulse_qualifier #(.SYNC_STAGES(2), .FILT_CYCLES(4), .HOLDOFF(16), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .async_in(async_in), .enable(enable),
        .clr_stats(clr_stats), .pulse_out(pulse_out2), .pulse_cnt(pulse_cnt2),
        .dropped(dropped2)
    );

    // Count pulses and any pulse that stays high for more than one cycle.
    always @(posedge clk) begin
        if (pulse_out) seen <= seen + 1;
        if (pulse_out && prev_p) long_cnt <= long_cnt + 1;
        prev_p <= pulse_out;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; async_in = 1'b0; enable = 1'b1; clr_stats = 1'b0;
        step(5);
        chk("rst_pulse", 32'(pulse_out), 32'd0);
        chk("rst_cnt", 32'(pulse_cnt), 32'd0);
        chk("rst_drop", 32'(dropped), 32'd0);
        reset = 1'b0;
        step(6);

        // 1: latency and single-cycle pulse
        async_in = 1'b1;
        step(5); chk("t1_e5", 32'(pulse_out), 32'd0);
        step(1); chk("t1_e6", 32'(pulse_out), 32'd1);
        chk("t1_cnt_e6", 32'(pulse_cnt), 32'd0);
        step(1); chk("t1_e7", 32'(pulse_out), 32'd0);
        chk("t1_cnt", 32'(pulse_cnt), 32'd1);
        step(3); async_in = 1'b0;
        step(25);
        chk("t1_drop", 32'(dropped), 32'd0);
        chk("t1_seen", 32'(seen), 32'd1);

        // 2: filter rejects short high, restarts on low
        clr_stats = 1'b1; step(1); clr_stats = 1'b0;
        chk("t2_clr", 32'(pulse_cnt), 32'd0);
        async_in = 1'b1; step(3); async_in = 1'b0;
        step(10);
        chk("t2_short_seen", 32'(seen), 32'd1);
        chk("t2_short_cnt", 32'(pulse_cnt), 32'd0);
        async_in = 1'b1; step(2); async_in = 1'b0; step(1);
        async_in = 1'b1; step(4); async_in = 1'b0;
        step(25);
        chk("t2_seen", 32'(seen), 32'd2);
        chk("t2_cnt", 32'(pulse_cnt), 32'd1);

        // 3: input stuck high through reset never fires
        async_in = 1'b1; reset = 1'b1; step(5); reset = 1'b0;
        chk("t3_after_rst", 32'(pulse_out), 32'd0);
        step(50);
        chk("t3_stuck_seen", 32'(seen), 32'd2);
        chk("t3_stuck_cnt", 32'(pulse_cnt), 32'd0);
        async_in = 1'b0; step(3);
        async_in = 1'b1; step(8); async_in = 1'b0;
        step(25);
        chk("t3_seen", 32'(seen), 32'd3);
        chk("t3_cnt", 32'(pulse_cnt), 32'd1);

        // 4: re-trigger during holdoff is dropped
        async_in = 1'b1; step(8); async_in = 1'b0; step(2);
        async_in = 1'b1; step(3); async_in = 1'b0; step(2);
        chk("t4_drop", 32'(dropped), 32'd1);
        step(20);
        chk("t4_seen", 32'(seen), 32'd4);
        chk("t4_cnt", 32'(pulse_cnt), 32'd2);
        clr_stats = 1'b1; step(1); clr_stats = 1'b0;
        chk("t4_clr_cnt", 32'(pulse_cnt), 32'd0);
        chk("t4_clr_drop", 32'(dropped), 32'd0);

        // 5: counter saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            async_in = 1'b1; step(6); async_in = 1'b0; step(24);
            if (i == 1) chk("t5_cnt2_two", 32'(pulse_cnt2), 32'd2);
        end
        chk("t5_seen", 32'(seen), 32'd9);
        chk("t5_cnt", 32'(pulse_cnt), 32'd5);
        chk("t5_cnt2_sat", 32'(pulse_cnt2), 32'd3);

        // 6a: reset mid-filter aborts
        async_in = 1'b1; step(4);
        reset = 1'b1; async_in = 1'b0; step(3);
        chk("t6a_rst_pulse", 32'(pulse_out), 32'd0);
        chk("t6a_rst_cnt", 32'(pulse_cnt), 32'd0);
        chk("t6a_rst_cnt2", 32'(pulse_cnt2), 32'd0);
        chk("t6a_rst_drop", 32'(dropped), 32'd0);
        reset = 1'b0; step(5);
        chk("t6a_no_pulse", 32'(seen), 32'd9);
        async_in = 1'b1; step(8); async_in = 1'b0; step(25);
        chk("t6a_seen", 32'(seen), 32'd10);
        chk("t6a_cnt", 32'(pulse_cnt), 32'd1);

        // 6b: enable low mid-filter aborts, stats held
        async_in = 1'b1; step(4);
        enable = 1'b0; step(10);
        chk("t6b_dis_seen", 32'(seen), 32'd10);
        chk("t6b_dis_pulse", 32'(pulse_out), 32'd0);
        chk("t6b_dis_cnt", 32'(pulse_cnt), 32'd1);
        async_in = 1'b0; step(5);
        enable = 1'b1; step(3);
        async_in = 1'b1; step(8); async_in = 1'b0; step(25);
        chk("t6b_seen", 32'(seen), 32'd11);
        chk("t6b_cnt", 32'(pulse_cnt), 32'd2);

        // clr_stats in the FIRE cycle wins over the increment
        async_in = 1'b1; step(6);
        chk("clrfire_pulse", 32'(pulse_out), 32'd1);
        clr_stats = 1'b1; step(1); clr_stats = 1'b0;
        chk("clrfire_cnt", 32'(pulse_cnt), 32'd0);
        async_in = 1'b0; step(25);

        // enable dropped during FIRE: pulse still counted
        async_in = 1'b1; step(6);
        chk("enfire_pulse", 32'(pulse_out), 32'd1);
        enable = 1'b0; step(1);
        chk("enfire_cnt", 32'(pulse_cnt), 32'd1);
        chk("enfire_off", 32'(pulse_out), 32'd0);
        async_in = 1'b0; step(3); enable = 1'b1; step(25);
        chk("final_seen", 32'(seen), 32'd13);
        chk("single_cycle", 32'(long_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
